alu_seq_fsm: RTL and testbench

Parametrised ALU-operation sequencer; successor to the fixed 6-bit, add-only controller. Accepts one instruction (opCode plus two operand addresses) per start handshake, then walks the datapath through fetch, operand loads, execute, result capture, writeback and PC increment. Adds over the previous generation:
- configurable widths;
- unary and NOP opcodes;
- multi-cycle execute;
- busy/done handshake;
- back-to-back issue.

All outputs are flop-based, with no latches.

---
 rtl/alu_seq_pkg.sv | 10 +
 rtl/alu_seq_fsm_if.sv | 35 +++
 rtl/alu_seq_fsm.sv | 87 ++++++++
 tb/tb_alu_seq_fsm.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding and opcode decode helpers for alu_seq_fsm.
package alu_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD_A, LOAD_B, EXEC, CAPTURE, WRITE, INCR} state_t;
  function automatic logic [31:0] nop_code(int w);
    return (32'd1 << w) - 32'd1;
  endfunction
  function automatic logic is_unary(logic [31:0] op, int w);
    return op[w-1];
  endfunction
endpackage

// File: rtl/alu_seq_fsm_if.sv
// alu_seq_fsm_if: instruction request and datapath control bundle; aluDone exists only with ALU_SEQ_WAIT_EN.
interface alu_seq_fsm_if #(parameter int PARA_W = 6, parameter int OPC_W = 4);
  logic start;
  logic [OPC_W-1:0] opCode;
  logic [PARA_W-1:0] para1;
  logic [PARA_W-1:0] para2;
`ifdef ALU_SEQ_WAIT_EN
  logic aluDone;
`endif
  logic busy;
  logic done;
  logic fetch;
  logic [PARA_W-1:0] paraOut;
  logic aluIn1;
  logic aluIn2;
  logic [OPC_W-1:0] control;
  logic aluOutRegIn;
  logic aluOutRegOut;
  logic [PARA_W-1:0] regIn;
  logic incr;
  modport master (
`ifdef ALU_SEQ_WAIT_EN
    output aluDone,
`endif
    output start, opCode, para1, para2,
    input busy, done, fetch, paraOut, aluIn1, aluIn2, control, aluOutRegIn, aluOutRegOut, regIn, incr
  );
  modport slave (
`ifdef ALU_SEQ_WAIT_EN
    input aluDone,
`endif
    input start, opCode, para1, para2,
    output busy, done, fetch, paraOut, aluIn1, aluIn2, control, aluOutRegIn, aluOutRegOut, regIn, incr
  );
endinterface

// File: rtl/alu_seq_fsm.sv
// alu_seq_fsm: ALU instruction sequencer; define ALU_SEQ_WAIT_EN to end EXEC on aluDone instead of a fixed cycle count.
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int PARA_W = 6,
  parameter int OPC_W = 4,
  parameter int EXEC_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  alu_seq_fsm_if.slave bus
);
  localparam logic [OPC_W-1:0] NOP = OPC_W'(nop_code(OPC_W));
  state_t state, nxt;
  logic [OPC_W-1:0] op_q, op_n;
  logic [PARA_W-1:0] p1_q, p1_n, p2_q, p2_n;
  logic accept, exec_end;
`ifdef ALU_SEQ_WAIT_EN
  assign exec_end = bus.aluDone;
`else
  localparam int CW = EXEC_CYCLES > 1 ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(EXEC_CYCLES - 1);
  logic [CW-1:0] cnt, cnt_n;
  assign exec_end = cnt == '0;
  assign cnt_n = (nxt == EXEC && state != EXEC) ? CNT_INIT : (state == EXEC && cnt != '0) ? cnt - 1'b1 : cnt;
`endif
  always_comb begin
    accept = bus.start && (state == IDLE || state == INCR);
    op_n = accept ? bus.opCode : op_q;
    p1_n = accept ? bus.para1 : p1_q;
    p2_n = accept ? bus.para2 : p2_q;
    nxt = state;
    unique case (state)
      IDLE:    nxt = accept ? FETCH : IDLE;
      FETCH:   nxt = op_q == NOP ? INCR : LOAD_A;
      LOAD_A:  nxt = is_unary(32'(op_q), OPC_W) ? EXEC : LOAD_B;
      LOAD_B:  nxt = EXEC;
      EXEC:    nxt = exec_end ? CAPTURE : EXEC;
      CAPTURE: nxt = WRITE;
      WRITE:   nxt = INCR;
      INCR:    nxt = accept ? FETCH : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
`ifndef ALU_SEQ_WAIT_EN
      cnt <= '0;
`endif
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.fetch <= 1'b0;
      bus.paraOut <= '0;
      bus.aluIn1 <= 1'b0;
      bus.aluIn2 <= 1'b0;
      bus.control <= '0;
      bus.aluOutRegIn <= 1'b0;
      bus.aluOutRegOut <= 1'b0;
      bus.regIn <= '0;
      bus.incr <= 1'b0;
    end else begin
      state <= nxt;
      op_q <= op_n;
      p1_q <= p1_n;
      p2_q <= p2_n;
`ifndef ALU_SEQ_WAIT_EN
      cnt <= cnt_n;
`endif
      bus.busy <= nxt != IDLE;
      bus.done <= nxt == INCR;
      bus.fetch <= nxt == FETCH;
      bus.paraOut <= nxt == LOAD_A ? p1_q : nxt == LOAD_B ? p2_q : '0;
      bus.aluIn1 <= nxt == LOAD_A;
      bus.aluIn2 <= nxt == LOAD_B;
      bus.control <= (nxt == EXEC || nxt == CAPTURE) ? op_q : '0;
      bus.aluOutRegIn <= nxt == CAPTURE;
      bus.aluOutRegOut <= nxt == WRITE;
      bus.regIn <= nxt == WRITE ? p1_q : '0;
      bus.incr <= nxt == INCR;
    end
  end
endmodule

// File: tb/tb_alu_seq_fsm.sv
// tb_alu_seq_fsm: scoreboard bench; two instances (EXEC_CYCLES 1 and 3), per-instruction traces checked on done.
module tb_alu_seq_fsm;
  typedef struct {
    int lat, pa, pb, n1, n2, ne, ctl, rg, nw, ninc, gap, nb;
  } rec_t;
  logic clk, reset;
  int checks, failures;
  rec_t q0[$], q1[$];
  rec_t ob[2];
  logic act[2];
  int since[2];
  alu_seq_fsm_if #(.PARA_W(6), .OPC_W(4)) b0();
  alu_seq_fsm_if #(.PARA_W(6), .OPC_W(4)) b1();
  alu_seq_fsm #(.PARA_W(6), .OPC_W(4), .EXEC_CYCLES(1)) u0 (.clk(clk), .reset(reset), .bus(b0));
  alu_seq_fsm #(.PARA_W(6), .OPC_W(4), .EXEC_CYCLES(3)) u1 (.clk(clk), .reset(reset), .bus(b1));
  logic [1:0] m_fetch, m_a1, m_a2, m_cap, m_wr, m_done, m_incr, m_busy;
  logic [5:0] m_po[2], m_rg[2];
  logic [3:0] m_ctl[2];
  assign m_fetch = {b1.fetch, b0.fetch};
  assign m_a1 = {b1.aluIn1, b0.aluIn1};
  assign m_a2 = {b1.aluIn2, b0.aluIn2};
  assign m_cap = {b1.aluOutRegIn, b0.aluOutRegIn};
  assign m_wr = {b1.aluOutRegOut, b0.aluOutRegOut};
  assign m_done = {b1.done, b0.done};
  assign m_incr = {b1.incr, b0.incr};
  assign m_busy = {b1.busy, b0.busy};
  assign m_po[0] = b0.paraOut;
  assign m_po[1] = b1.paraOut;
  assign m_rg[0] = b0.regIn;
  assign m_rg[1] = b1.regIn;
  assign m_ctl[0] = b0.control;
  assign m_ctl[1] = b1.control;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int a, int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic bad(string nm);
    checks++;
    failures++;
    $display("FAIL %s got=timeout/unexpected exp=event", nm);
  endtask

  function automatic rec_t mk(int lat, int pa, int pb, int n1, int n2, int ne, int ctl, int rg, int nw, int gap);
    rec_t r;
    r.lat = lat; r.pa = pa; r.pb = pb; r.n1 = n1; r.n2 = n2; r.ne = ne;
    r.ctl = ctl; r.rg = rg; r.nw = nw; r.ninc = 1; r.gap = gap; r.nb = 0;
    return r;
  endfunction

  function automatic logic [23:0] outs(int k);
    return k == 0 ?
      {b0.fetch, b0.paraOut, b0.aluIn1, b0.aluIn2, b0.control, b0.aluOutRegIn, b0.aluOutRegOut, b0.regIn, b0.incr, b0.done, b0.busy} :
      {b1.fetch, b1.paraOut, b1.aluIn1, b1.aluIn2, b1.control, b1.aluOutRegIn, b1.aluOutRegOut, b1.regIn, b1.incr, b1.done, b1.busy};
  endfunction

  task automatic cmp(int k, rec_t o);
    rec_t e;
    string p;
    p = $sformatf("u%0d", k);
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      bad({p, ".unexpected_done"});
      return;
    end
    e = k == 0 ? q0.pop_front() : q1.pop_front();
    chk({p, ".lat"}, o.lat, e.lat);
    chk({p, ".paraA"}, o.pa, e.pa);
    chk({p, ".paraB"}, o.pb, e.pb);
    chk({p, ".n_aluIn1"}, o.n1, e.n1);
    chk({p, ".n_aluIn2"}, o.n2, e.n2);
    chk({p, ".exec_len"}, o.ne, e.ne);
    chk({p, ".control"}, o.ctl, e.ctl);
    chk({p, ".regIn"}, o.rg, e.rg);
    chk({p, ".n_write"}, o.nw, e.nw);
    chk({p, ".n_incr"}, o.ninc, e.ninc);
    chk({p, ".busy_drop"}, o.nb, e.nb);
    if (e.gap >= 0) chk({p, ".b2b_gap"}, o.gap, e.gap);
  endtask

  // Monitor: builds a trace of each instruction from fetch to done and checks it on done.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        act[k] = 1'b0;
        since[k] = 1000;
      end else begin
        since[k]++;
        if (m_fetch[k]) begin
          if (act[k]) bad($sformatf("u%0d.fetch_before_done", k));
          act[k] = 1'b1;
          ob[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, since[k] - 1);
          ob[k].ninc = 0;
        end
        if (act[k]) begin
          ob[k].lat++;
          if (m_a1[k]) begin ob[k].n1++; ob[k].pa = int'(m_po[k]); end
          if (m_a2[k]) begin ob[k].n2++; ob[k].pb = int'(m_po[k]); end
          if (m_ctl[k] != 0 && !m_cap[k]) ob[k].ne++;
          if (m_cap[k]) ob[k].ctl = int'(m_ctl[k]);
          if (m_wr[k]) begin ob[k].nw++; ob[k].rg = int'(m_rg[k]); end
          if (m_incr[k]) ob[k].ninc++;
          if (!m_busy[k]) ob[k].nb++;
        end
        if (m_done[k]) begin
          since[k] = 0;
          if (!act[k]) bad($sformatf("u%0d.done_without_fetch", k));
          else cmp(k, ob[k]);
          act[k] = 1'b0;
        end
      end
    end
  end

  task automatic set_in(int k, logic s, logic [3:0] op, logic [5:0] a, logic [5:0] b);
    if (k == 0) begin
      b0.start = s; b0.opCode = op; b0.para1 = a; b0.para2 = b;
    end else begin
      b1.start = s; b1.opCode = op; b1.para1 = a; b1.para2 = b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one instruction from IDLE, scrambles the operands afterwards, optionally pulses start mid-flight.
  task automatic issue(int k, logic [3:0] op, logic [5:0] a, logic [5:0] b, rec_t e, int pulse);
    int c;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    set_in(k, 1'b1, op, a, b);
    tick();
    set_in(k, 1'b0, ~op, ~a, ~b);
    c = 1;
    while (m_busy[k] && c < 60) begin
      if (c == pulse) set_in(k, 1'b1, 4'hF, 6'h3F, 6'h3F);
      else set_in(k, 1'b0, ~op, ~a, ~b);
      tick();
      c++;
    end
    set_in(k, 1'b0, 4'h0, 6'h00, 6'h00);
    if (c >= 60) bad($sformatf("u%0d.issue_timeout", k));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    set_in(0, 1'b0, 4'h0, 6'h00, 6'h00);
    set_in(1, 1'b0, 4'h0, 6'h00, 6'h00);
    #12;
    chk("u0.reset_outs", int'(outs(0)), 0);
    chk("u1.reset_outs", int'(outs(1)), 0);
    tick();
    reset = 1'b1;
    tick();
    issue(0, 4'h2, 6'h05, 6'h0A, mk(7, 'h05, 'h0A, 1, 1, 1, 'h2, 'h05, 1, -1), 0);
    issue(0, 4'hA, 6'h11, 6'h22, mk(6, 'h11, 0, 1, 0, 1, 'hA, 'h11, 1, -1), 0);
    issue(0, 4'hF, 6'h07, 6'h08, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, -1), 0);
    issue(1, 4'h9, 6'h03, 6'h04, mk(8, 'h03, 0, 1, 0, 3, 'h9, 'h03, 1, -1), 0);
    issue(1, 4'h5, 6'h2A, 6'h15, mk(9, 'h2A, 'h15, 1, 1, 3, 'h5, 'h2A, 1, -1), 0);
    issue(0, 4'h1, 6'h06, 6'h09, mk(7, 'h06, 'h09, 1, 1, 1, 'h1, 'h06, 1, -1), 3);
    issue(1, 4'h6, 6'h0B, 6'h0C, mk(9, 'h0B, 'h0C, 1, 1, 3, 'h6, 'h0B, 1, -1), 5);
    // Back-to-back: start stays high, second instruction accepted in INCR.
    q1.push_back(mk(9, 'h01, 'h02, 1, 1, 3, 'h3, 'h01, 1, -1));
    q1.push_back(mk(8, 'h3F, 0, 1, 0, 3, 'hC, 'h3F, 1, 0));
    set_in(1, 1'b1, 4'h3, 6'h01, 6'h02);
    tick();
    set_in(1, 1'b1, 4'hC, 6'h3F, 6'h00);
    c = 0;
    while (!m_done[1] && c < 60) begin tick(); c++; end
    if (c >= 60) bad("u1.b2b_first_done");
    tick();
    set_in(1, 1'b0, 4'h0, 6'h00, 6'h00);
    c = 0;
    while (m_busy[1] && c < 60) begin tick(); c++; end
    if (c >= 60) bad("u1.b2b_second_done");
    tick();
    // Reset in the middle of EXEC; the aborted instruction never reports done.
    set_in(0, 1'b1, 4'h2, 6'h05, 6'h0A);
    tick();
    set_in(0, 1'b0, 4'h0, 6'h00, 6'h00);
    tick();
    tick();
    tick();
    chk("u0.exec_control_n4", int'(b0.control), 'h2);
    reset = 1'b0;
    #1;
    chk("u0.midreset_outs", int'(outs(0)), 0);
    chk("u0.midreset_busy", int'(b0.busy), 0);
    tick();
    reset = 1'b1;
    tick();
    issue(0, 4'h6, 6'h0C, 6'h0D, mk(7, 'h0C, 'h0D, 1, 1, 1, 'h6, 'h0C, 1, -1), 0);
    tick();
    tick();
    chk("u0.queue_drained", q0.size(), 0);
    chk("u1.queue_drained", q1.size(), 0);
    chk("u0.idle_outs", int'(outs(0)), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
